// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
// Contents: fetch FSM state enum, default reset PC, ebreak mask/match
// constants and a small ebreak decode helper.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // ebreak encoding, ignoring the don't-care fields of the SYSTEM opcode
  localparam logic [31:0] EBREAK_MASK  = 32'hFFF0_707F;
  localparam logic [31:0] EBREAK_MATCH = 32'h0010_0073;

  function automatic logic is_ebreak(input logic [31:0] word);
    return (word & EBREAK_MASK) == EBREAK_MATCH;
  endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: next-PC selection for the fetch unit (redirect > pc+4 > hold).
// Ports: pc_i current PC, redirect_en_i/redirect_pc_i redirect request,
//        advance_i current instruction consumed, pc_next_o next-state PC.
// Purely combinational, zero latency; no flow control of its own.
module ifu_pc_gen (
  input  logic [31:0] pc_i,
  input  logic        redirect_en_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_next_o
);

  // Fetch addresses are always word aligned; the low target bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    pc_next_o = pc_i;
    if (redirect_en_i) begin
      pc_next_o = {redirect_pc_i[31:2], 2'b00};
    end else if (advance_i) begin
      // 32-bit add wraps naturally: FFFF_FFFC + 4 -> 0
      pc_next_o = pc_i + 32'd4;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch FSM with instruction hold register.
// Latency: request handshake N, response N+1, inst_valid N+2; decode stalls via inst_ready.
// Ports: imem_req_* request (valid/ready), imem_rsp_* response, inst_* to decode,
//        redirect_* from execute, pc current PC, halted ebreak stop indication.
// Optional feature macro IFU_EBREAK_HALT_EN: consuming an ebreak stops fetch in HALT
// until reset; when undefined, halted is tied low and HALT is never entered.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;

  logic        redirect_en;
  logic        consume;

  // IDLE and HALT ignore redirects; every other state steers the PC.
  assign redirect_en = redirect_valid && (state_q inside {FETCH, WAIT, HOLD});
  assign consume     = (state_q == HOLD) && inst_ready;

  ifu_pc_gen u_pc_gen (
    .pc_i          (pc_q),
    .redirect_en_i (redirect_en),
    .redirect_pc_i (redirect_pc),
    .advance_i     (consume),
    .pc_next_o     (pc_d)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_req_ready) begin
          state_d = WAIT;
          // A redirect in the handshake cycle makes the in-flight word stale.
          drop_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (redirect_valid) drop_d = 1'b1;
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          // A redirect landing in the same cycle as the response also kills it.
          if (drop_q || redirect_valid) begin
            state_d = FETCH;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready || redirect_valid) state_d = FETCH;
`ifdef IFU_EBREAK_HALT_EN
        if (inst_ready && is_ebreak(inst_q)) state_d = HALT;
`endif
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  // Control outputs decode registered state only.
  assign imem_req_valid = (state_q == FETCH);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign pc             = pc_q;
`ifdef IFU_EBREAK_HALT_EN
  assign halted         = (state_q == HALT);
`else
  assign halted         = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   n_consumed = 0;

  // test-controlled stimulus knobs, applied by step()
  logic        t_rst = 1'b1;
  logic        t_req_ready = 1'b1;
  logic        t_inst_ready = 1'b1;
  logic        t_redirect = 1'b0;
  logic [31:0] t_target = '0;
  logic        t_force_rsp = 1'b0;
  logic        rnd_en = 1'b0;
  logic        ebreak_en = 1'b0;
  logic [31:0] ebreak_addr = '0;

  // memory model state
  logic        pend = 1'b0;
  logic        pend_drop = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Instruction memory contents: a hash of the address, never an ebreak
  // unless the ebreak slot is armed.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (ebreak_en && a == ebreak_addr) return EBREAK;
    h = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    return {h[31:7], 7'h13};
  endfunction

  // One clock: drive all inputs 2 time units after the rising edge and run
  // the memory model. Responses that will reach decode are pushed to sb.
  task automatic step();
    logic hs;
    @(posedge clk);
    #2;
    rst = t_rst;
    if (rnd_en) begin
      imem_req_ready = ($urandom_range(0, 2) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = {16'h8000, 16'($urandom)};
    end else begin
      imem_req_ready = t_req_ready;
      inst_ready     = t_inst_ready;
      redirect_valid = t_redirect;
      redirect_pc    = t_target;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    hs = imem_req_valid && imem_req_ready && !rst;
    if (rst) begin
      pend = 1'b0;
      if (t_force_rsp) imem_rsp_valid = 1'b1;
    end else if (pend) begin
      if (redirect_valid) pend_drop = 1'b1;
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend = 1'b0;
        if (!pend_drop) sb.push_back('{pend_addr, mem_word(pend_addr)});
      end
    end else if (t_force_rsp || (rnd_en && $urandom_range(0, 3) == 0)) begin
      imem_rsp_valid = 1'b1;  // stray response with no outstanding request
    end
    if (hs) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_drop = redirect_valid;
      pend_cnt  = rnd_en ? int'($urandom_range(1, 3)) : 1;
    end
  endtask

  // Monitor: architectural model of the fetch stream, checked on the falling edge.
  logic [31:0] exp_pc = RESET_PC;
  logic        m_halt = 1'b0;
  logic        prev_rst = 1'b1;
  logic        halt_next;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_pc   = RESET_PC;
      m_halt   = 1'b0;
      prev_rst = 1'b1;
    end else begin
      halt_next = 1'b0;
      chk("halted", 32'(halted), 32'(m_halt));
      if (m_halt) chk("halt_no_req", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid && imem_req_ready) chk("req_addr", imem_req_addr, exp_pc);
      if (inst_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL inst_unexpected: got inst_valid pc %h inst %h, required none", pc, inst);
        end else begin
          chk("inst_dat", inst, sb[0].data);
          chk("inst_pc", pc, sb[0].addr);
          if (inst_ready || redirect_valid) begin
            mon_e = sb.pop_front();
            if (inst_ready) begin
              n_consumed++;
`ifdef IFU_EBREAK_HALT_EN
              if ((mon_e.data & 32'hFFF0_707F) == EBREAK) halt_next = 1'b1;
`endif
            end
          end
        end
      end
      if (redirect_valid && !prev_rst && !m_halt) exp_pc = {redirect_pc[31:2], 2'b00};
      else if (inst_valid && inst_ready)          exp_pc = exp_pc + 32'd4;
      if (halt_next) m_halt = 1'b1;
      prev_rst = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int n_req;
    logic [31:0] hpc, hinst;
    logic seen8;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // reset state
    t_rst = 1'b1;
    repeat (3) step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", inst, 32'd0);

    // back-to-back fetch with zero-wait memory: one instruction every 3 cycles
    t_rst = 1'b0; t_req_ready = 1'b1; t_inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("seq_inst_valid", 32'(inst_valid), 32'(k >= 3 && k % 3 == 0));
      chk("seq_req_valid", 32'(imem_req_valid), 32'(k % 3 == 1));
      if (k % 3 == 1) chk("seq_req_addr", imem_req_addr, RESET_PC + 32'(4 * ((k - 1) / 3)));
    end

    // decode stall in HOLD
    t_inst_ready = 1'b0;
    step();
    n = 0;
    while (!inst_valid && n < 10) begin step(); n++; end
    chk("stall_reach_hold", 32'(inst_valid), 32'd1);
    hpc = pc; hinst = inst;
    repeat (5) begin
      step();
      chk("stall_inst_valid", 32'(inst_valid), 32'd1);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      chk("stall_pc", pc, hpc);
      chk("stall_inst", inst, hinst);
    end
    t_inst_ready = 1'b1;
    step();
    step();
    chk("stall_release_req", 32'(imem_req_valid), 32'd1);
    chk("stall_release_addr", imem_req_addr, hpc + 32'd4);

    // redirect while waiting for the response (handshake happened above)
    t_redirect = 1'b1; t_target = 32'h8000_0103;
    step();
    t_redirect = 1'b0;
    step();
    chk("wait_redir_inst_valid", 32'(inst_valid), 32'd0);
    chk("wait_redir_req", 32'(imem_req_valid), 32'd1);
    chk("wait_redir_addr", imem_req_addr, 32'h8000_0100);

    // redirect and consume in the same HOLD cycle
    t_inst_ready = 1'b0;
    step();
    n = 0;
    while (!inst_valid && n < 10) begin step(); n++; end
    chk("hold_redir_reach_hold", 32'(inst_valid), 32'd1);
    t_redirect = 1'b1; t_target = 32'h8000_0200; t_inst_ready = 1'b1;
    step();
    t_redirect = 1'b0;
    step();
    chk("hold_redir_req", 32'(imem_req_valid), 32'd1);
    chk("hold_redir_addr", imem_req_addr, 32'h8000_0200);

    // reset while waiting, then a late response
    t_rst = 1'b1;
    step();
    t_force_rsp = 1'b1;
    step();
    t_rst = 1'b0;
    step();
    step();
    chk("late_rsp_inst_valid", 32'(inst_valid), 32'd0);
    chk("late_rsp_req", 32'(imem_req_valid), 32'd1);
    chk("late_rsp_addr", imem_req_addr, RESET_PC);
    t_force_rsp = 1'b0;
    repeat (3) step();

    // ebreak at RESET_PC+4
    t_rst = 1'b1;
    repeat (2) step();
    ebreak_en = 1'b1; ebreak_addr = RESET_PC + 32'd4;
    t_rst = 1'b0;
    seen8 = 1'b0;
    repeat (12) begin
      step();
      if (imem_req_valid && imem_req_addr == RESET_PC + 32'd8) seen8 = 1'b1;
    end
    t_redirect = 1'b1; t_target = 32'h8000_0400;
    n_req = 0;
    repeat (20) begin
      step();
      if (imem_req_valid) n_req++;
    end
`ifdef IFU_EBREAK_HALT_EN
    chk("ebreak_halted", 32'(halted), 32'd1);
    chk("ebreak_no_next", 32'(seen8), 32'd0);
    chk("ebreak_req_count", 32'(n_req), 32'd0);
`else
    chk("ebreak_halted", 32'(halted), 32'd0);
    chk("ebreak_next_fetch", 32'(seen8), 32'd1);
    chk("ebreak_req_seen", 32'(n_req != 0), 32'd1);
`endif
    t_redirect = 1'b0;
    t_rst = 1'b1;
    step();
    step();
    chk("ebreak_rst_clears", 32'(halted), 32'd0);
    ebreak_en = 1'b0;

    // randomized traffic
    t_rst = 1'b0;
    step();
    rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0; t_inst_ready = 1'b1; t_req_ready = 1'b1; t_redirect = 1'b0;
    repeat (20) step();
    t_req_ready = 1'b0;
    repeat (6) step();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("random_consumed", 32'(n_consumed > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h8000_0000, PC loaded on reset.
REQ-002 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 SHALL provide imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL provide imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL provide imem_rsp_valid  input  1  response data valid.
REQ-008 SHALL provide imem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL provide inst_valid  output  1  instruction available to decode.
REQ-010 SHALL provide inst_ready  input  1  decode consumes instruction.
REQ-011 SHALL provide inst  output  32  held instruction word.
REQ-012 SHALL provide pc  output  32  PC of held instruction / current fetch.
REQ-013 SHALL provide redirect_valid  input  1  branch/jump redirect from execute.
REQ-014 SHALL provide redirect_pc  input  32  redirect target.
REQ-015 SHALL provide halted  output  1  fetch stopped on ebreak.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT, HOLD, HALT; at most one outstanding request.
REQ-017 IDLE SHALL assert no outputs and go to FETCH unconditionally next cycle.
REQ-018 FETCH SHALL drive imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-019 WAIT SHALL capture imem_rsp_data into inst on imem_rsp_valid and go to HOLD; response can arrive no earlier than the cycle after the request handshake.
REQ-020 HOLD SHALL assert inst_valid with inst and pc stable; on inst_ready: pc <= pc+4, -> FETCH.
REQ-021 Minimum issue-to-inst_valid latency SHALL be 2 cycles (handshake cycle N, response N+1, inst_valid N+2).
REQ-022 redirect_valid SHALL have priority over pc+4: pc <= {redirect_pc[31:2],2'b00} in every state except IDLE/HALT.
REQ-023 Redirect in FETCH coinciding with request handshake, or redirect in WAIT, SHALL set a drop flag; response received with drop set SHALL be discarded and state -> FETCH.
REQ-024 Redirect in HOLD SHALL deassert inst_valid next cycle and go to FETCH; if inst_ready is high the same cycle, instruction counts as consumed and pc takes redirect target, not pc+4.
REQ-025 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-026 pc arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).
REQ-027 imem_req_valid, inst_valid, halted SHALL derive from registered state only (no input-to-output combinational path).

Reset
REQ-028 While rst is sampled high: state=IDLE, pc=RESET_PC, inst=0, drop flag=0, imem_req_valid=0, inst_valid=0, halted=0.
REQ-029 rst mid-transaction SHALL abandon any outstanding request; later responses are ignored (state not WAIT).

Configuration
REQ-030 With IFU_EBREAK_HALT_EN defined: when a HOLD instruction satisfies (inst & 32'hFFF0707F)==32'h0010_0073 and is consumed, state -> HALT; HALT issues no requests, ignores redirect, halted=1 sticky until rst.
REQ-031 Without IFU_EBREAK_HALT_EN: no ebreak detection, HALT unreachable, halted tied 0.

Structure
REQ-032 Package ifu_pkg SHALL hold the state enum, default RESET_PC, EBREAK_MASK/EBREAK_MATCH constants.
REQ-033 Next-PC selection (redirect / pc+4 / hold) SHALL live in one sub-module ifu_pc_gen; FSM and instruction register stay in ifu_fetch.

Verification
REQ-034 Reset release, memory ready=1, 1-cycle response, inst_ready=1: addresses 8000_0000, 8000_0004, 8000_0008 issued; inst_valid every 3rd cycle.
REQ-035 inst_ready held 0 for 5 cycles in HOLD: inst, pc stable, no new request; release -> next addr pc+4.
REQ-036 Redirect to 32'h8000_0103 in WAIT: response dropped, inst_valid stays 0, next request addr 8000_0100.
REQ-037 Redirect and inst_ready same HOLD cycle, target 8000_0200: next request 8000_0200, not pc+4.
REQ-038 With IFU_EBREAK_HALT_EN, fetch returns 32'h0010_0073: after consumption halted=1, imem_req_valid stays 0 for 20 cycles despite redirect; rst clears; without macro fetch continues at pc+4.
REQ-039 rst asserted in WAIT then late rsp_valid: ignored, first request after release at RESET_PC.
